// File: rtl/bus_transfer_sequencer.sv
// Shared-bus transfer sequencer: turns MOVE/SWAP/LOAD/STORE commands into
// registered per-register load/drive strobes and external-port strobes.
module bus_transfer_sequencer #(
    parameter int NREG     = 8,
    parameter int IDXW     = 3,
    parameter int TEMP_IDX = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [IDXW-1:0] cmd_src,
    input  logic [NREG-1:0] cmd_dst_mask,
    output logic [NREG-1:0] R_in,
    output logic [NREG-1:0] R_out,
    output logic            ext_drive,
    output logic            ext_capture,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {IDLE, X1, X2, X3, FIN, ERR} state_e;
    typedef enum logic [1:0] {OP_MOVE, OP_SWAP, OP_LOAD, OP_STORE} op_e;

    localparam logic [NREG-1:0] TEMP_OH = NREG'(1) << TEMP_IDX;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [IDXW-1:0] src_q, src_d;
    logic [NREG-1:0] mask_q, mask_d;
    logic [NREG-1:0] r_in_q, r_in_d, r_out_q, r_out_d;
    logic            ext_drive_q, ext_drive_d, ext_capture_q, ext_capture_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic            cmd_ready_q, cmd_ready_d;

    logic [NREG-1:0] src_oh;
    logic            src_ok;
    logic            bad;
    logic            accept;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        mask_d  = mask_q;
        accept  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    op_d    = op_e'(cmd_op);
                    src_d   = cmd_src;
                    mask_d  = cmd_dst_mask;
                    state_d = X1;
                end
            end
            X1:      state_d = (op_q == OP_SWAP) ? X2 : FIN;
            X2:      state_d = X3;
            X3:      state_d = FIN;
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes for the cycle after the edge are derived from the command
        // as latched at that edge, so outputs leave the flops already valid.
        src_oh = NREG'(1) << src_d;
        src_ok = int'(src_d) < NREG;

        bad = 1'b0;
        unique case (op_d)
            OP_MOVE:  bad = !src_ok || (mask_d == '0);
            OP_LOAD:  bad = (mask_d == '0);
            OP_STORE: bad = !src_ok;
            OP_SWAP:  bad = !src_ok || !$onehot(mask_d) || (mask_d == src_oh)
                            || (src_oh == TEMP_OH) || ((mask_d & TEMP_OH) != '0);
            default:  bad = 1'b1;
        endcase
        if (accept && bad) begin
            state_d = ERR;
        end

        r_in_d        = '0;
        r_out_d       = '0;
        ext_drive_d   = 1'b0;
        ext_capture_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        cmd_ready_d   = 1'b0;
        busy_d        = (state_d != IDLE);

        unique case (state_d)
            IDLE: cmd_ready_d = 1'b1;
            X1: begin
                unique case (op_d)
                    OP_MOVE: begin
                        r_out_d = src_oh;
                        r_in_d  = mask_d & ~src_oh;
                    end
                    OP_LOAD: begin
                        ext_drive_d = 1'b1;
                        r_in_d      = mask_d;
                    end
                    OP_STORE: begin
                        r_out_d       = src_oh;
                        ext_capture_d = 1'b1;
                    end
                    OP_SWAP: begin
                        r_out_d = src_oh;
                        r_in_d  = TEMP_OH;
                    end
                    default: ;
                endcase
            end
            X2: begin
                r_out_d = mask_d;
                r_in_d  = src_oh;
            end
            X3: begin
                r_out_d = TEMP_OH;
                r_in_d  = mask_d;
            end
            FIN:     done_d = 1'b1;
            ERR:     err_d  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= OP_MOVE;
            src_q         <= '0;
            mask_q        <= '0;
            r_in_q        <= '0;
            r_out_q       <= '0;
            ext_drive_q   <= 1'b0;
            ext_capture_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            cmd_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            src_q         <= src_d;
            mask_q        <= mask_d;
            r_in_q        <= r_in_d;
            r_out_q       <= r_out_d;
            ext_drive_q   <= ext_drive_d;
            ext_capture_q <= ext_capture_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            cmd_ready_q   <= cmd_ready_d;
        end
    end

    assign R_in        = r_in_q;
    assign R_out       = r_out_q;
    assign ext_drive   = ext_drive_q;
    assign ext_capture = ext_capture_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cmd_ready   = cmd_ready_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed + random bench for bus_transfer_sequencer with a per-cycle
// expected-strobe queue and a behavioural model of the shared data bus.
module tb_bus_transfer_sequencer;

    localparam logic [1:0] MOVE  = 2'b00;
    localparam logic [1:0] SWAP  = 2'b01;
    localparam logic [1:0] LOAD  = 2'b10;
    localparam logic [1:0] STORE = 2'b11;
    localparam logic [21:0] IDLE_V = 22'h000001;

    typedef struct packed {
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ed;
        logic       ec;
        logic       dn;
        logic       er;
    } step_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_src;
    logic [7:0] cmd_dst_mask;
    logic [7:0] R_in, R_out;
    logic       ext_drive, ext_capture, busy, done, err;

    logic [7:0] ext_data;
    logic [7:0] ext_sink;
    logic [7:0] regs [8];
    logic [7:0] bus;

    step_t exp_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    bus_transfer_sequencer #(.NREG(8), .IDXW(3), .TEMP_IDX(7)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst_mask(cmd_dst_mask),
        .R_in(R_in), .R_out(R_out), .ext_drive(ext_drive), .ext_capture(ext_capture),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Register units and external port as they would respond to the strobes.
    always @(posedge clk) begin
        bus = ext_drive ? ext_data : 8'hxx;
        for (int i = 0; i < 8; i++) if (R_out[i]) bus = regs[i];
        for (int i = 0; i < 8; i++) if (R_in[i]) regs[i] <= bus;
        if (ext_capture) ext_sink <= bus;
    end

    function automatic logic [21:0] obs();
        return {R_in, R_out, ext_drive, ext_capture, busy, done, err, cmd_ready};
    endfunction

    function automatic logic [21:0] exp_of(step_t s);
        return {s.rin, s.rout, s.ed, s.ec, 1'b1, s.dn, s.er, 1'b0};
    endfunction

    task automatic check(string tag, logic [21:0] o, logic [21:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic inv();
        check("inv_rout_onehot0", 22'($onehot0(R_out)), 22'd1);
        check("inv_one_driver", 22'(ext_drive && (R_out != 8'h00)), 22'd0);
        check("inv_rin_undriven", 22'(!ext_drive && (R_out == 8'h00) && (R_in != 8'h00)), 22'd0);
    endtask

    task automatic push_expected(logic [1:0] op, logic [2:0] src, logic [7:0] mask);
        logic [7:0] sb;
        logic       ok;
        sb = 8'd1 << src;
        case (op)
            MOVE:    ok = (mask != 8'h00);
            LOAD:    ok = (mask != 8'h00);
            STORE:   ok = 1'b1;
            default: ok = $onehot(mask) && (mask != sb) && (src != 3'd7) && !mask[7];
        endcase
        if (!ok) begin
            exp_q.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        end else begin
            case (op)
                MOVE:  exp_q.push_back('{mask & ~sb, sb, 1'b0, 1'b0, 1'b0, 1'b0});
                LOAD:  exp_q.push_back('{mask, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
                STORE: exp_q.push_back('{8'h00, sb, 1'b0, 1'b1, 1'b0, 1'b0});
                default: begin
                    exp_q.push_back('{8'h80, sb, 1'b0, 1'b0, 1'b0, 1'b0});
                    exp_q.push_back('{sb, mask, 1'b0, 1'b0, 1'b0, 1'b0});
                    exp_q.push_back('{mask, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0});
                end
            endcase
            exp_q.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        end
    endtask

    // Called at a falling edge with the DUT idle; runs one command to idle.
    task automatic do_cmd(string tag, logic [1:0] op, logic [2:0] src, logic [7:0] mask);
        step_t s;
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_src      = src;
        cmd_dst_mask = mask;
        push_expected(op, src, mask);
        @(posedge clk);
        #1;
        cmd_valid    = 1'b0;
        cmd_op       = 2'($urandom);
        cmd_src      = 3'($urandom);
        cmd_dst_mask = 8'($urandom);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            inv();
            s = exp_q.pop_front();
            check(tag, obs(), exp_of(s));
        end
        @(negedge clk);
        inv();
        check({tag, "_idle"}, obs(), IDLE_V);
    endtask

    initial begin
        step_t      s;
        logic [7:0] m;
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = MOVE;
        cmd_src      = 3'd0;
        cmd_dst_mask = 8'h00;
        ext_data     = 8'h00;

        @(negedge clk);
        check("reset_state", obs(), IDLE_V);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("after_release", obs(), IDLE_V);

        ext_data = 8'h5A;
        do_cmd("load_all", LOAD, 3'd0, 8'hFF);
        for (int i = 0; i < 8; i++) check("load_all_data", 22'(regs[i]), 22'h5A);
        ext_data = 8'h11;
        do_cmd("load_r1", LOAD, 3'd0, 8'h02);
        ext_data = 8'h22;
        do_cmd("load_r2", LOAD, 3'd0, 8'h04);
        ext_data = 8'h33;
        do_cmd("load_r3", LOAD, 3'd0, 8'h08);

        do_cmd("move_2_to_45", MOVE, 3'd2, 8'b0011_0100);
        check("move_r4", 22'(regs[4]), 22'h22);
        check("move_r5", 22'(regs[5]), 22'h22);
        check("move_r2_kept", 22'(regs[2]), 22'h22);

        do_cmd("move_self_only", MOVE, 3'd2, 8'h04);

        do_cmd("swap_1_3", SWAP, 3'd1, 8'h08);
        check("swap_r1", 22'(regs[1]), 22'h33);
        check("swap_r3", 22'(regs[3]), 22'h11);

        do_cmd("store_6", STORE, 3'd6, 8'h00);
        check("store_data", 22'(ext_sink), 22'h5A);

        do_cmd("err_swap_src7", SWAP, 3'd7, 8'h01);
        do_cmd("err_swap_mask06", SWAP, 3'd0, 8'h06);
        do_cmd("err_move_mask0", MOVE, 3'd3, 8'h00);
        do_cmd("err_swap_dst_eq_src", SWAP, 3'd4, 8'h10);
        do_cmd("err_swap_dst_temp", SWAP, 3'd2, 8'h80);

        // Command fields change every cycle; only those present in IDLE count.
        for (int i = 0; i < 9; i++) begin
            cmd_valid    = 1'b1;
            cmd_op       = MOVE;
            cmd_src      = 3'(i);
            cmd_dst_mask = 8'hFF;
            if (i % 3 == 0) push_expected(MOVE, 3'(i), 8'hFF);
            @(negedge clk);
            inv();
            if (i % 3 == 2) begin
                check("b2b_idle", obs(), IDLE_V);
            end else begin
                s = exp_q.pop_front();
                check("b2b_step", obs(), exp_of(s));
            end
        end
        cmd_valid = 1'b0;
        exp_q.delete();

        cmd_valid    = 1'b1;
        cmd_op       = SWAP;
        cmd_src      = 3'd1;
        cmd_dst_mask = 8'h08;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_swap_x1", obs(), exp_of('{8'h80, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        check("rst_swap_x2", obs(), exp_of('{8'h02, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0}));
        #2 reset = 1'b1;
        #1 check("rst_async", obs(), IDLE_V);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            inv();
            check("rst_no_x3", obs(), IDLE_V);
        end

        for (int n = 0; n < 1000; n++) begin
            ext_data = 8'($urandom);
            if ($urandom_range(1, 0) == 1) m = 8'd1 << $urandom_range(7, 0);
            else m = 8'($urandom);
            do_cmd("random", 2'($urandom), 3'($urandom), m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
